core_featuremap_conv2d_0_feeder: RTL and testbench
==================================================

CORE_FEATUREMAP_CONV2D_0_FEEDER -- requirements
Module: core_featuremap_conv2d_0_feeder

Interface
REQ-001 Parameter DWIDTH, 32, width of one channel sample and of one source FIFO word.
REQ-002 Parameter FRAME_PIXELS, 1024, packed pixels per frame; used only when FEEDER_PIXEL_COUNT_EN is defined.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ff_rdata  input  DWIDTH  source FIFO word, show-ahead: valid whenever ff_empty=0.
REQ-006 ff_rdreq  output  1  source FIFO pop; a word is consumed in each cycle ff_rdreq=1.
REQ-007 ff_empty  input  1  source FIFO empty flag.
REQ-008 ff_wdata  output  DWIDTH*3  packed 3-channel pixel word to the conv2d input FIFO.
REQ-009 ff_wrreq  output  1  sink FIFO push; one packed word is written in each cycle ff_wrreq=1.
REQ-010 ff_full  input  1  sink FIFO full flag.
REQ-011 pix_count  output  16  packed pixels written in the current frame; present only with FEEDER_PIXEL_COUNT_EN.
REQ-012 frame_done  output  1  one-cycle pulse on the final pixel write of a frame; present only with FEEDER_PIXEL_COUNT_EN.

Function
REQ-013 The block SHALL pack three consecutive source words into one ff_wdata word: first word in [DWIDTH-1:0], second word in [2*DWIDTH-1:DWIDTH], third word in [3*DWIDTH-1:2*DWIDTH].
REQ-014 The FSM SHALL have two states: FILL (collecting words; channel counter ch=0..2) and HOLD (packed word complete, awaiting sink space).
REQ-015 In FILL, ff_rdreq SHALL equal NOT ff_empty (combinational); ff_wrreq SHALL be 0.
REQ-016 On each FILL pop, ff_rdata SHALL be registered into the lane selected by ch, and ch SHALL increment.
REQ-017 The pop at ch=2 SHALL set ch to 0 and move the FSM to HOLD on the same edge.
REQ-018 In HOLD, ff_rdreq SHALL be 0, and ff_wrreq SHALL equal NOT ff_full (combinational).
REQ-019 A HOLD cycle with ff_full=0 SHALL push ff_wdata and return the FSM to FILL on the next edge.
REQ-020 While ff_full=1 in HOLD, the FSM SHALL stay in HOLD with ff_wdata stable; no word is lost or duplicated.
REQ-021 ff_wdata SHALL be driven only from the pack register, never from ff_rdata directly, and SHALL change only on pops.
REQ-022 An empty source during FILL SHALL stall the FSM; ch and already-captured lanes SHALL be preserved.
REQ-023 Peak throughput SHALL be one packed word per 4 cycles (3 pops + 1 push); latency from the third pop to ff_wrreq=1 SHALL be 1 cycle when ff_full=0.
REQ-024 ff_full SHALL be ignored in FILL, and ff_empty SHALL be ignored in HOLD.

Reset
REQ-025 Reset SHALL force the FSM to FILL, ch=0, and the pack register (ff_wdata) to 0.
REQ-026 ff_rdreq and ff_wrreq SHALL both be 0 during any cycle with reset=1, regardless of the FIFO flags.
REQ-027 Reset asserted mid-pixel or in HOLD SHALL discard any partial or pending pixel; the next pop after reset SHALL be lane 0.
REQ-028 With the macro defined, reset SHALL clear pix_count to 0 and frame_done to 0.

Configuration
REQ-029 With macro FEEDER_PIXEL_COUNT_EN defined, each push SHALL increment pix_count; at FRAME_PIXELS-1 it SHALL wrap to 0, and frame_done SHALL be registered high for exactly the cycle after that push.
REQ-030 Without FEEDER_PIXEL_COUNT_EN, pix_count, frame_done and their logic SHALL be absent, and packing behaviour SHALL be identical.

Verification
REQ-031 Scenario: source holds 0x11,0x22,0x33, sink never full -> after 3 pops, ff_wrreq=1 for one cycle with ff_wdata=0x00000033_00000022_00000011.
REQ-032 Scenario: ff_full=1 for 10 cycles while in HOLD -> ff_wrreq=0, ff_rdreq=0, ff_wdata stable; ff_full drops -> exactly one push.
REQ-033 Scenario: ff_empty toggles every cycle across 6 words -> exactly 2 pushes with correct lane order, no duplicated or skipped words.
REQ-034 Scenario: reset pulsed after 2 pops, then words 0xA,0xB,0xC -> push 0x0000000C_0000000B_0000000A.
REQ-035 Scenario: continuous stream, ff_full=0 -> one push every 4 cycles, ff_rdreq pattern 1,1,1,0 repeating.
REQ-036 Scenario (macro defined, FRAME_PIXELS=4): 4 pixels pushed -> pix_count 1,2,3,0; frame_done high exactly once, in the cycle after the 4th push.

Source files
------------

// File: rtl/core_featuremap_conv2d_0_feeder.sv
// Packs three consecutive DWIDTH source words into one 3-lane pixel word for the conv2d input FIFO.
// Optional macro FEEDER_PIXEL_COUNT_EN adds a per-frame pixel counter and a frame_done pulse.
module core_featuremap_conv2d_0_feeder #(
    parameter int DWIDTH       = 32,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DWIDTH-1:0]   ff_rdata,
    output logic                ff_rdreq,
    input  logic                ff_empty,
    output logic [3*DWIDTH-1:0] ff_wdata,
    output logic                ff_wrreq,
    input  logic                ff_full
`ifdef FEEDER_PIXEL_COUNT_EN
    ,
    output logic [15:0]         pix_count,
    output logic                frame_done
`endif
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ch_q, ch_d;
    logic [3*DWIDTH-1:0] pack_q, pack_d;
    logic                pop_s;
    logic                push_s;

    // FIFO handshakes; reset masks both strobes whatever the FIFO flags say.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (reset) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            case (state_q)
                FILL:    pop_s  = ~ff_empty;
                HOLD:    push_s = ~ff_full;
                default: begin
                    pop_s  = 1'b0;
                    push_s = 1'b0;
                end
            endcase
        end
    end

    assign ff_rdreq = pop_s;
    assign ff_wrreq = push_s;
    assign ff_wdata = pack_q;

    // Next state, channel counter and lane capture.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pack_d  = pack_q;
        case (state_q)
            FILL: begin
                if (pop_s) begin
                    case (ch_q)
                        2'd0:    pack_d[DWIDTH-1:0]          = ff_rdata;
                        2'd1:    pack_d[2*DWIDTH-1:DWIDTH]   = ff_rdata;
                        2'd2:    pack_d[3*DWIDTH-1:2*DWIDTH] = ff_rdata;
                        default: pack_d = pack_q;
                    endcase
                    if (ch_q == 2'd2) begin
                        ch_d    = 2'd0;
                        state_d = HOLD;
                    end else if (ch_q == 2'd3) begin
                        // Unreachable code point: resynchronise to lane 0 without capturing.
                        ch_d    = 2'd0;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                    end
                end else begin
                    ch_d = ch_q;
                end
            end
            HOLD: begin
                if (push_s) begin
                    state_d = FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                ch_d    = 2'd0;
            end
        endcase
    end

    // State, channel and pack registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            ch_q    <= 2'd0;
            pack_q  <= {(3*DWIDTH){1'b0}};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pack_q  <= pack_d;
        end
    end

`ifdef FEEDER_PIXEL_COUNT_EN
    localparam logic [15:0] LAST_PIX = 16'(FRAME_PIXELS - 1);

    logic [15:0] pix_q, pix_d;
    logic        done_q, done_d;

    // Pixel counter wraps on the last pixel of a frame and flags it for one cycle.
    always_comb begin
        pix_d  = pix_q;
        done_d = 1'b0;
        if (push_s) begin
            if (pix_q == LAST_PIX) begin
                pix_d  = 16'd0;
                done_d = 1'b1;
            end else begin
                pix_d  = pix_q + 16'd1;
            end
        end else begin
            pix_d = pix_q;
        end
    end

    // Frame counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q  <= 16'd0;
            done_q <= 1'b0;
        end else begin
            pix_q  <= pix_d;
            done_q <= done_d;
        end
    end

    assign pix_count  = pix_q;
    assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_core_featuremap_conv2d_0_feeder.sv
// Self-checking bench for core_featuremap_conv2d_0_feeder: vector table, corner sequences,
// and randomized traffic against a word-queue reference model.
module tb_core_featuremap_conv2d_0_feeder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ff_rdata = 32'h0;
    logic        ff_rdreq;
    logic        ff_empty = 1'b1;
    logic [95:0] ff_wdata;
    logic        ff_wrreq;
    logic        ff_full = 1'b0;
`ifdef FEEDER_PIXEL_COUNT_EN
    logic [15:0] pix_count;
    logic        frame_done;
`endif

    core_featuremap_conv2d_0_feeder #(.DWIDTH(32), .FRAME_PIXELS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .ff_rdata (ff_rdata),
        .ff_rdreq (ff_rdreq),
        .ff_empty (ff_empty),
        .ff_wdata (ff_wdata),
        .ff_wrreq (ff_wrreq),
        .ff_full  (ff_full)
`ifdef FEEDER_PIXEL_COUNT_EN
        ,
        .pix_count  (pix_count),
        .frame_done (frame_done)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: a pixel is simply the next three accepted source words.
    bit          m_pend = 1'b0;
    logic [31:0] m_got[$];
    logic [95:0] m_pix[$];
    logic [95:0] m_wd = 96'h0;
    logic        m_exp_rd, m_exp_wr;
    int          push_cnt = 0;
    logic [95:0] last_push = 96'h0;

    always @(negedge clock) begin
        #3;
        m_exp_rd = !reset && !m_pend && !ff_empty;
        m_exp_wr = !reset && m_pend && !ff_full;
        chk("model_rdreq", {95'h0, ff_rdreq}, {95'h0, m_exp_rd});
        chk("model_wrreq", {95'h0, ff_wrreq}, {95'h0, m_exp_wr});
        chk("model_wdata", ff_wdata, m_wd);
        if (m_exp_wr && m_pix.size() > 0) chk("model_pixel", ff_wdata, m_pix[0]);
        if (ff_wrreq) begin
            push_cnt++;
            last_push = ff_wdata;
        end
        if (reset) begin
            m_got.delete();
            m_pix.delete();
            m_pend = 1'b0;
            m_wd   = 96'h0;
        end else if (!m_pend) begin
            if (!ff_empty) begin
                m_wd[32*m_got.size() +: 32] = ff_rdata;
                m_got.push_back(ff_rdata);
                if (m_got.size() == 3) begin
                    m_pix.push_back({m_got[2], m_got[1], m_got[0]});
                    m_got.delete();
                    m_pend = 1'b1;
                end
            end
        end else if (!ff_full) begin
            m_pend = 1'b0;
            void'(m_pix.pop_front());
        end
    end

    task automatic tick(input logic r, input logic e, input logic f, input logic [31:0] d);
        @(negedge clock);
        reset    = r;
        ff_empty = e;
        ff_full  = f;
        ff_rdata = d;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        emp;
        logic        full;
        logic [31:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [95:0] exp_wd;
    } vec_t;

    vec_t vecs[9];
    int   p0;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 96'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 1'b0, 96'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h11, 1'b1, 1'b0, 96'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 96'h00000000_00000000_00000011};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h33, 1'b1, 1'b0, 96'h00000000_00000022_00000011};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 96'h00000033_00000022_00000011};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 96'h00000033_00000022_00000011};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h55, 1'b0, 1'b0, 96'h00000033_00000022_00000044};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 96'h0};
        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].rst, vecs[i].emp, vecs[i].full, vecs[i].rdata);
            chk($sformatf("vec%0d_rdreq", i), {95'h0, ff_rdreq}, {95'h0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_wrreq", i), {95'h0, ff_wrreq}, {95'h0, vecs[i].exp_wr});
            chk($sformatf("vec%0d_wdata", i), ff_wdata, vecs[i].exp_wd);
        end

        // Sink back-pressure while a pixel is pending.
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h101);
        tick(1'b0, 1'b0, 1'b1, 32'h202);
        tick(1'b0, 1'b0, 1'b1, 32'h303);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b1, 32'h404);
            chk("full_rdreq", {95'h0, ff_rdreq}, 96'h0);
            chk("full_wrreq", {95'h0, ff_wrreq}, 96'h0);
            chk("full_wdata", ff_wdata, 96'h00000303_00000202_00000101);
        end
        p0 = push_cnt;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("release_wrreq", {95'h0, ff_wrreq}, 96'h1);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("after_push_wrreq", {95'h0, ff_wrreq}, 96'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("release_push_count", 96'(push_cnt - p0), 96'd1);

        // Source empty toggling every cycle across six words.
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        p0 = push_cnt;
        for (int i = 0; i < 12; i++) tick(1'b0, logic'(i % 2), 1'b0, 32'h600 + 32'(i / 2));
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("toggle_push_count", 96'(push_cnt - p0), 96'd2);
        chk("toggle_last_pixel", last_push, 96'h00000605_00000604_00000603);

        // Reset mid-pixel discards the partial pixel.
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 32'h2);
        tick(1'b1, 1'b0, 1'b0, 32'h3);
        chk("reset_rdreq", {95'h0, ff_rdreq}, 96'h0);
        tick(1'b0, 1'b0, 1'b0, 32'hA);
        tick(1'b0, 1'b0, 1'b0, 32'hB);
        tick(1'b0, 1'b0, 1'b0, 32'hC);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("reset_push_wrreq", {95'h0, ff_wrreq}, 96'h1);
        chk("reset_push_wdata", ff_wdata, 96'h0000000C_0000000B_0000000A);

        // Continuous stream: rdreq 1,1,1,0 repeating.
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 1'b0, $urandom);
            chk($sformatf("stream%0d_rdreq", i), {95'h0, ff_rdreq}, {95'h0, logic'(i % 4 != 3)});
            chk($sformatf("stream%0d_wrreq", i), {95'h0, ff_wrreq}, {95'h0, logic'(i % 4 == 3)});
        end

        // Randomized traffic, checked by the model every cycle.
        p0 = push_cnt;
        for (int i = 0; i < 600; i++)
            tick(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 2) == 0), $urandom);
        checks++;
        if (push_cnt - p0 < 10) begin
            errors++;
            $display("FAIL random_pushes: got %0d expected at least 10", push_cnt - p0);
        end

`ifdef FEEDER_PIXEL_COUNT_EN
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0, $urandom);
            chk($sformatf("frame%0d_pix_count", i), {80'h0, pix_count}, 96'((i / 4) % 4));
            chk($sformatf("frame%0d_frame_done", i), {95'h0, frame_done}, {95'h0, logic'(i == 16)});
        end
`endif

        tick(1'b1, 1'b1, 1'b0, 32'h0);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
